bus_mux_reg: RTL and testbench
==============================

# bus_mux_reg

Parametrised, registered successor to the datapath bus multiplexer. Selects one of `NSRC` sources, each `WIDTH` bits wide, using one-hot `<reg>out`-style enables, and drives the shared internal bus. When no source is enabled, the bus holds its last driven value instead of floating. Optionally detects and counts multi-driver conflicts. Sits between the register file, special registers (HI, LO, Z, PC, MDR, IR) and every bus consumer.

## Interface
Parameters:
- `WIDTH`, default 32: data width of each source and of the bus.
- `NSRC`, default 24: number of bus sources. Legal range 2..64.
- `REG_OUT`, default 1: 1 inserts an output register stage; 0 gives combinational data with a registered hold value.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `clear_n`, input, 1: reset. Synchronous, active-low.
- `src_data`, input, `NSRC*WIDTH`: concatenated sources. Source i occupies `[i*WIDTH +: WIDTH]`.
- `src_out`, input, `NSRC`: one-hot output enables. Bit i requests source i.
- `bus_out`, output, `WIDTH`: bus value.
- `bus_valid`, output, 1: `bus_out` reflects a source driven this transfer, not a held value.
- `sel_idx`, output, `$clog2(NSRC)`: index of the winning source. Aligned with `bus_out`.
- `conflict`, output, 1: more than one enable was active for the transfer shown on `bus_out`.
- `conflict_count`, output, 16: saturating count of conflict cycles.

## Operation
- Encoder: the winner is the lowest-index asserted bit of `src_out` (priority, not OR-merge). Data is never ANDed or ORed across sources.
- Any bit asserted: a transfer.
  - `bus_out` = winner's data, `bus_valid`=1, `sel_idx` = winner index.
  - Hold register `held` <= winner's data.
- No bit asserted:
  - `bus_out` = `held`, `bus_valid`=0, `sel_idx` keeps its previous value.
  - The bus never drives Z or X.
- `conflict` = popcount(`src_out`) >= 2. Each conflict cycle increments `conflict_count`.
  - Saturates at 16'hFFFF, no wrap.
  - Cleared only by reset.
- Reset (`clear_n`=0 at a rising edge): `held`, `bus_out`, `sel_idx`, `conflict_count` = 0; `bus_valid`, `conflict` = 0.
  - Reset wins over a simultaneous transfer. That transfer is discarded and not counted.
- State: `held` register, optional output pipeline register, and the counter. No FSM beyond the hold/valid behaviour.

## Timing
- `REG_OUT`=1:
  - `bus_out`, `bus_valid`, `sel_idx` and `conflict` appear one cycle after the enables are sampled. Latency 1, throughput 1 per cycle.
  - Back-to-back different sources produce back-to-back outputs with no bubble.
- `REG_OUT`=0:
  - `bus_out`, `bus_valid`, `sel_idx` and `conflict` are combinational from `src_out`/`src_data` in the same cycle.
  - `held`, `sel_idx` retention and `conflict_count` still update on the edge.
- `conflict_count` updates on the edge after the conflict cycle in both modes.
- Enable deasserted after a transfer: `bus_out` keeps that transfer's value, aligned to the same latency; `bus_valid` drops to 0.
- Reset mid-stream: outputs are 0 the cycle after the reset edge (`REG_OUT`=1), or immediately after the edge for registered state (`REG_OUT`=0).
- `NSRC` not a power of two: unused `sel_idx` codes never appear.

## Configuration
- `BUS_CONFLICT_CHECK_EN` defined:
  - popcount logic, the `conflict` output and `conflict_count` are compiled in.
  - Simulation-only: an `$error` is issued on every conflict cycle.
- Not defined:
  - `conflict` is tied 0 and `conflict_count` tied 16'h0000. No popcount logic.
  - Priority selection is unchanged, so multi-driver cycles still resolve to the lowest index.

## Test plan
- Reset then sweep, `REG_OUT`=1:
  - Stimulus: each `src_data[i]` = 32'hA000_0000+i; assert `src_out` = 1<<i for i=0..23, one per cycle.
  - Required: cycle i+1 shows `bus_out` = 32'hA000_0000+i, `sel_idx`=i, `bus_valid`=1.
- Hold:
  - Stimulus: drive source 5 (32'hDEAD_BEEF) for one cycle, then `src_out`=0 for 4 cycles.
  - Required: `bus_out` stays 32'hDEAD_BEEF, `bus_valid`=0, `sel_idx`=5.
- Conflict, with `BUS_CONFLICT_CHECK_EN`:
  - Stimulus: `src_out` = bits 3 and 7, with src3=32'h3, src7=32'h7.
  - Required: `bus_out`=32'h3, `sel_idx`=3, `conflict`=1, `conflict_count` goes 0->1.
  - Without the macro: `conflict` stays 0 and `conflict_count` stays 0.
- Saturation:
  - Stimulus: force 65,540 consecutive conflict cycles.
  - Required: `conflict_count` = 16'hFFFF and stays there.
- Reset mid-operation:
  - Stimulus: source 2 active with `clear_n`=0 on the same edge.
  - Required: next cycle `bus_out`=0, `bus_valid`=0, `conflict_count`=0. The subsequent hold value is 0.
- `REG_OUT`=0, `WIDTH`=16, `NSRC`=4:
  - Stimulus: `src_out`=4'b0100, src2=16'h1234.
  - Required: same-cycle `bus_out`=16'h1234, `sel_idx`=2.
  - After the enable drops: `bus_out` stays 16'h1234.

Source files
------------

// File: rtl/bus_mux_reg_if.sv
// Bus mux port bundle: the concatenated sources and enables going in, and the
// resolved bus value with its status coming out.
// The master modport belongs to the mux; the slave modport is for source/consumer blocks.
interface bus_mux_reg_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 24
);
    localparam int SEL_W = $clog2(NSRC);

    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_out;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [SEL_W-1:0]      sel_idx;
    logic                  conflict;
    logic [15:0]           conflict_count;

    modport master (
        input  src_data, src_out,
        output bus_out, bus_valid, sel_idx, conflict, conflict_count
    );

    modport slave (
        output src_data, src_out,
        input  bus_out, bus_valid, sel_idx, conflict, conflict_count
    );
endinterface

// File: rtl/bus_mux_reg.sv
// Priority-select one of NSRC sources onto the shared bus, holding the last value when idle.
// Latency: 1 cycle with REG_OUT=1, 0 cycles (combinational) with REG_OUT=0.
// Backpressure: none; a transfer is accepted every cycle an enable is set.
// Optional feature macro: BUS_CONFLICT_CHECK_EN (multi-driver detection and counting).
module bus_mux_reg #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 24,
    parameter int REG_OUT = 1
) (
    input logic          clk,
    input logic          clear_n,
    bus_mux_reg_if.master bus
);
    localparam int SEL_W = $clog2(NSRC);

    logic             any_en;
    logic [SEL_W-1:0] win_idx;
    logic [WIDTH-1:0] win_dat;
    logic             conflict_now;
    logic [WIDTH-1:0] held;
    logic [SEL_W-1:0] sel_hold;
    logic [15:0]      conf_cnt;

    assign any_en = |bus.src_out;

    // Lowest-index enable wins; scanning downwards lets the lowest hit be the last write.
    always_comb begin
        win_idx = '0;
        win_dat = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (bus.src_out[i]) begin
                win_idx = SEL_W'(i);
                win_dat = bus.src_data[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef BUS_CONFLICT_CHECK_EN
    // Two or more enables set: clearing the lowest set bit still leaves one behind.
    always_comb begin
        conflict_now = |(bus.src_out & (bus.src_out - NSRC'(1)));
    end

    // Saturating count of conflict cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            conf_cnt <= '0;
        end else if (conflict_now && (conf_cnt != 16'hFFFF)) begin
            conf_cnt <= conf_cnt + 16'd1;
        end
    end

`ifndef SYNTHESIS
    // Flag every multi-driver cycle in simulation.
    always_ff @(posedge clk) begin
        if (clear_n && conflict_now) begin
            $error("bus_mux_reg: multiple bus drivers, src_out=%h", bus.src_out);
        end
    end
`endif
`else
    assign conflict_now = 1'b0;
    assign conf_cnt     = 16'h0000;
`endif

    // Hold register and retained index: capture the winner on every transfer.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            held     <= '0;
            sel_hold <= '0;
        end else if (any_en) begin
            held     <= win_dat;
            sel_hold <= win_idx;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic valid_q;
            logic conf_q;

            // Status flags registered alongside the data; held already tracks the bus value.
            always_ff @(posedge clk) begin
                if (!clear_n) begin
                    valid_q <= 1'b0;
                    conf_q  <= 1'b0;
                end else begin
                    valid_q <= any_en;
                    conf_q  <= conflict_now;
                end
            end

            assign bus.bus_out   = held;
            assign bus.sel_idx   = sel_hold;
            assign bus.bus_valid = valid_q;
            assign bus.conflict  = conf_q;
        end else begin : g_comb
            assign bus.bus_out   = any_en ? win_dat : held;
            assign bus.sel_idx   = any_en ? win_idx : sel_hold;
            assign bus.bus_valid = any_en;
            assign bus.conflict  = conflict_now;
        end
    endgenerate

    assign bus.conflict_count = conf_cnt;
endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: a registered 32x24 instance and a combinational 16x4 instance.
// Directed vector table, hand sequences and random traffic against a reference model.
// Follows BUS_CONFLICT_CHECK_EN for the expected conflict behaviour.
module tb_bus_mux_reg;
    localparam int WA = 32;
    localparam int NA = 24;
    localparam int WB = 16;
    localparam int NB = 4;
    localparam int SA = $clog2(NA);
    localparam int SB = $clog2(NB);
`ifdef BUS_CONFLICT_CHECK_EN
    localparam bit CONF_ON = 1'b1;
    localparam int SAT_N   = 65540;
`else
    localparam bit CONF_ON = 1'b0;
    localparam int SAT_N   = 300;
`endif

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    bus_mux_reg_if #(.WIDTH(WA), .NSRC(NA)) ifa ();
    bus_mux_reg_if #(.WIDTH(WB), .NSRC(NB)) ifb ();

    bus_mux_reg #(.WIDTH(WA), .NSRC(NA), .REG_OUT(1)) dut_a (.clk(clk), .clear_n(clear_n), .bus(ifa.master));
    bus_mux_reg #(.WIDTH(WB), .NSRC(NB), .REG_OUT(0)) dut_b (.clk(clk), .clear_n(clear_n), .bus(ifb.master));

    logic [WA-1:0] da [NA];
    logic [NA-1:0] ea;
    logic [WB-1:0] db [NB];
    logic [NB-1:0] eb;

    always_comb begin
        ifa.src_data = '0;
        for (int i = 0; i < NA; i++) ifa.src_data[i*WA +: WA] = da[i];
        ifa.src_out = ea;
    end
    always_comb begin
        ifb.src_data = '0;
        for (int i = 0; i < NB; i++) ifb.src_data[i*WB +: WB] = db[i];
        ifb.src_out = eb;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // First set bit of v, or -1 if none.
    function automatic int lowest(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference model: what each bus should show, derived from the selection rules.
    logic [WA-1:0] ma_held;
    logic [SA-1:0] ma_sel;
    logic          ma_valid;
    logic          ma_conf;
    logic [15:0]   ma_cnt;
    logic [WB-1:0] mb_held;
    logic [SB-1:0] mb_sel;
    logic [15:0]   mb_cnt;

    always @(posedge clk) begin
        if (!clear_n) begin
            ma_held <= '0; ma_sel <= '0; ma_valid <= 1'b0; ma_conf <= 1'b0; ma_cnt <= '0;
            mb_held <= '0; mb_sel <= '0; mb_cnt <= '0;
        end else begin
            if (ea != 0) begin
                ma_held <= da[lowest(64'(ea))];
                ma_sel  <= SA'(lowest(64'(ea)));
            end
            ma_valid <= (ea != 0);
            ma_conf  <= CONF_ON && ($countones(ea) >= 2);
            if (CONF_ON && ($countones(ea) >= 2) && (ma_cnt != 16'hFFFF)) ma_cnt <= ma_cnt + 16'd1;
            if (eb != 0) begin
                mb_held <= db[lowest(64'(eb))];
                mb_sel  <= SB'(lowest(64'(eb)));
            end
            if (CONF_ON && ($countones(eb) >= 2) && (mb_cnt != 16'hFFFF)) mb_cnt <= mb_cnt + 16'd1;
        end
    end

    task automatic check_a_model();
        chk("a_bus", 64'(ifa.bus_out), 64'(ma_held));
        chk("a_valid", 64'(ifa.bus_valid), 64'(ma_valid));
        chk("a_sel", 64'(ifa.sel_idx), 64'(ma_sel));
        chk("a_conflict", 64'(ifa.conflict), 64'(ma_conf));
        chk("a_count", 64'(ifa.conflict_count), 64'(ma_cnt));
    endtask

    task automatic check_b_model();
        int w;
        w = lowest(64'(eb));
        chk("b_bus", 64'(ifb.bus_out), (eb != 0) ? 64'(db[w]) : 64'(mb_held));
        chk("b_valid", 64'(ifb.bus_valid), 64'(eb != 0));
        chk("b_sel", 64'(ifb.sel_idx), (eb != 0) ? 64'(w) : 64'(mb_sel));
        chk("b_conflict", 64'(ifb.conflict), 64'(CONF_ON && ($countones(eb) >= 2)));
        chk("b_count", 64'(ifb.conflict_count), 64'(mb_cnt));
    endtask

    typedef struct {
        logic          clr;
        logic [NA-1:0] en;
        int            pat;  // 0: A000_0000+i, 1: same but src5=DEAD_BEEF, 2: src i = i
        logic [31:0]   bus;
        logic          vld;
        logic [SA-1:0] sel;
        logic          conf;
        logic [15:0]   cnt;
    } vec_t;

    function automatic vec_t mk(input logic clr, input logic [NA-1:0] en, input int pat,
                                input logic [31:0] bus, input logic vld, input int sel,
                                input logic conf, input logic [15:0] cnt);
        vec_t v;
        v.clr = clr; v.en = en; v.pat = pat; v.bus = bus;
        v.vld = vld; v.sel = SA'(sel); v.conf = conf; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        for (int i = 0; i < NA; i++) da[i] = '0;
        for (int i = 0; i < NB; i++) db[i] = '0;
        ea = '0;
        eb = '0;

        // Directed vectors for the registered instance, one per cycle.
        for (int i = 0; i < NA; i++)
            tbl.push_back(mk(1'b1, NA'(1) << i, 0, 32'hA000_0000 + 32'(i), 1'b1, i, 1'b0, 16'd0));
        tbl.push_back(mk(1'b1, NA'(1) << 5, 1, 32'hDEAD_BEEF, 1'b1, 5, 1'b0, 16'd0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b1, '0, 1, 32'hDEAD_BEEF, 1'b0, 5, 1'b0, 16'd0));
        tbl.push_back(mk(1'b1, (NA'(1) << 3) | (NA'(1) << 7), 2, 32'h3, 1'b1, 3, CONF_ON, 16'(CONF_ON)));
        tbl.push_back(mk(1'b1, '0, 2, 32'h3, 1'b0, 3, 1'b0, 16'(CONF_ON)));
        tbl.push_back(mk(1'b0, NA'(1) << 2, 0, 32'h0, 1'b0, 0, 1'b0, 16'd0));
        tbl.push_back(mk(1'b1, '0, 0, 32'h0, 1'b0, 0, 1'b0, 16'd0));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_bus", 64'(ifa.bus_out), 64'h0);
        chk("rst_a_valid", 64'(ifa.bus_valid), 64'h0);
        chk("rst_a_sel", 64'(ifa.sel_idx), 64'h0);
        chk("rst_a_conflict", 64'(ifa.conflict), 64'h0);
        chk("rst_a_count", 64'(ifa.conflict_count), 64'h0);
        chk("rst_b_bus", 64'(ifb.bus_out), 64'h0);
        chk("rst_b_valid", 64'(ifb.bus_valid), 64'h0);
        chk("rst_b_count", 64'(ifb.conflict_count), 64'h0);

        foreach (tbl[n]) begin
            clear_n = tbl[n].clr;
            ea = tbl[n].en;
            for (int i = 0; i < NA; i++) begin
                if (tbl[n].pat == 2) da[i] = 32'(i);
                else if (tbl[n].pat == 1 && i == 5) da[i] = 32'hDEAD_BEEF;
                else da[i] = 32'hA000_0000 + 32'(i);
            end
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_bus", n), 64'(ifa.bus_out), 64'(tbl[n].bus));
            chk($sformatf("vec%0d_valid", n), 64'(ifa.bus_valid), 64'(tbl[n].vld));
            chk($sformatf("vec%0d_sel", n), 64'(ifa.sel_idx), 64'(tbl[n].sel));
            chk($sformatf("vec%0d_conflict", n), 64'(ifa.conflict), 64'(tbl[n].conf));
            chk($sformatf("vec%0d_count", n), 64'(ifa.conflict_count), 64'(tbl[n].cnt));
        end
        clear_n = 1'b1;
        ea = '0;

        // Combinational instance: same-cycle select, then hold after the enable drops.
        db[0] = 16'h1111; db[1] = 16'hAAAA; db[2] = 16'h1234; db[3] = 16'hBBBB;
        eb = 4'b0100;
        #1;
        chk("b_same_bus", 64'(ifb.bus_out), 64'h1234);
        chk("b_same_sel", 64'(ifb.sel_idx), 64'h2);
        chk("b_same_valid", 64'(ifb.bus_valid), 64'h1);
        @(posedge clk);
        #1;
        eb = 4'b0000;
        #1;
        chk("b_hold_bus", 64'(ifb.bus_out), 64'h1234);
        chk("b_hold_valid", 64'(ifb.bus_valid), 64'h0);
        chk("b_hold_sel", 64'(ifb.sel_idx), 64'h2);
        eb = 4'b1010;
        #1;
        chk("b_conf_bus", 64'(ifb.bus_out), 64'hAAAA);
        chk("b_conf_sel", 64'(ifb.sel_idx), 64'h1);
        chk("b_conf_flag", 64'(ifb.conflict), 64'(CONF_ON));
        @(posedge clk);
        #1;
        eb = 4'b0000;
        #1;
        chk("b_conf_count", 64'(ifb.conflict_count), 64'(CONF_ON));
        chk("b_conf_hold", 64'(ifb.bus_out), 64'hAAAA);

        // Random traffic on both instances, with occasional resets.
        for (int it = 0; it < 400; it++) begin
            int mode;
            clear_n = ($urandom_range(0, 39) != 0);
            for (int i = 0; i < NA; i++) da[i] = $urandom;
            for (int i = 0; i < NB; i++) db[i] = WB'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0) ea = '0;
            else if (mode == 1) ea = NA'(1) << $urandom_range(0, NA - 1);
            else ea = NA'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0) eb = '0;
            else if (mode == 1) eb = NB'(1) << $urandom_range(0, NB - 1);
            else eb = NB'($urandom);
            #1;
            check_b_model();
            @(posedge clk);
            #1;
            check_a_model();
        end
        clear_n = 1'b1;
        eb = '0;

        // Long conflict burst: the counter must pin at its ceiling (or stay 0 when compiled out).
        for (int i = 0; i < NA; i++) da[i] = 32'(i);
        ea = (NA'(1) << 3) | (NA'(1) << 7);
        repeat (SAT_N) @(posedge clk);
        #1;
        chk("sat_count", 64'(ifa.conflict_count), CONF_ON ? 64'hFFFF : 64'h0);
        chk("sat_conflict", 64'(ifa.conflict), 64'(CONF_ON));
        chk("sat_bus", 64'(ifa.bus_out), 64'h3);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_count_stays", 64'(ifa.conflict_count), CONF_ON ? 64'hFFFF : 64'h0);
        check_a_model();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
